// File: rtl/rx_check_module.sv
// rx_check_module: per-port egress receive checker (framing, length, destination, statistics).
// Optional payload sequence check is compiled in when RX_PAYLOAD_CHECK_EN is defined.
//   state   | meaning
//   IDLE    | waiting for a header beat
//   PAYLOAD | counting payload beats of the current packet
//   DRAIN   | length reached without eop, discarding beats until eop
module rx_check_module #(
  parameter int RX_PORT         = 0,
  parameter int PORT_NUB        = 4,
  parameter int PRIORITY        = 8,
  parameter int DATA_LENGTH_MAX = 256,
  parameter int DATA_WIDTH      = 32,
  localparam int WIDTH_SEL      = $clog2(PORT_NUB),
  localparam int WIDTH_PRIORITY = $clog2(PRIORITY),
  localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold,
  input  logic                      rd_sop,
  input  logic                      rd_eop,
  input  logic                      rd_vld,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      ready,
  output logic                      pkt_done,
  output logic [WIDTH_LENGTH-1:0]   last_len,
  output logic [WIDTH_PRIORITY-1:0] last_prio,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               err_cnt,
  output logic [2:0]                err_code,
  output logic                      err_flag
);

  localparam int HDR_W = WIDTH_SEL + WIDTH_PRIORITY + WIDTH_LENGTH;

  localparam logic [2:0] CODE_ORPHAN = 3'd1;
  localparam logic [2:0] CODE_SOP    = 3'd2;
  localparam logic [2:0] CODE_LEN    = 3'd3;
  localparam logic [2:0] CODE_DEST   = 3'd4;
  localparam logic [2:0] CODE_DATA   = 3'd5;
  localparam logic [2:0] CODE_SHORT  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                    state;
  logic [WIDTH_LENGTH:0]     k;
  logic [WIDTH_LENGTH-1:0]   len_q;
  logic [WIDTH_PRIORITY-1:0] prio_q;
  logic                      pkt_err;

  logic [WIDTH_SEL-1:0]      hdr_dest;
  logic [WIDTH_PRIORITY-1:0] hdr_prio;
  logic [WIDTH_LENGTH-1:0]   hdr_len;
  logic                      hdr_short;
  logic                      hdr_dest_bad;
  logic [WIDTH_LENGTH:0]     k_inc;
  logic                      at_len;
  logic                      payload_beat;
  logic                      data_bad;
  logic                      unused_bits;

  assign hdr_dest     = rd_data[WIDTH_SEL-1:0];
  assign hdr_prio     = rd_data[WIDTH_SEL +: WIDTH_PRIORITY];
  assign hdr_len      = rd_data[WIDTH_SEL+WIDTH_PRIORITY +: WIDTH_LENGTH];
  assign hdr_short    = rd_eop | (hdr_len == '0);
  assign hdr_dest_bad = (hdr_dest != WIDTH_SEL'(RX_PORT));
  assign k_inc        = k + (WIDTH_LENGTH+1)'(1);
  assign at_len       = (k_inc == {1'b0, len_q});
  assign payload_beat = rd_vld & ~rd_sop & (state == S_PAYLOAD);
  assign unused_bits  = ^rd_data[DATA_WIDTH-1:HDR_W];

`ifdef RX_PAYLOAD_CHECK_EN
  // Only the first sequence mismatch of a packet is reported.
  logic        data_seen;
  logic [15:0] k_ref;
  assign k_ref    = 16'(k);
  assign data_bad = payload_beat & ~data_seen & (rd_data[15:0] != k_ref);
`else
  assign data_bad = 1'b0;
`endif

  logic ev_sop, ev_short, ev_len, ev_dest, ev_data, ev_orphan;
  logic good;

  always_comb begin
    ev_sop    = 1'b0;
    ev_short  = 1'b0;
    ev_len    = 1'b0;
    ev_dest   = 1'b0;
    ev_data   = 1'b0;
    ev_orphan = 1'b0;
    good      = 1'b0;
    if (rd_vld) begin
      if (rd_sop) begin
        ev_sop   = (state != S_IDLE);
        ev_short = hdr_short;
        ev_dest  = hdr_dest_bad;
      end else begin
        case (state)
          S_IDLE: ev_orphan = 1'b1;
          S_PAYLOAD: begin
            ev_data = data_bad;
            if (at_len && rd_eop) good = ~pkt_err & ~data_bad;
            else if (at_len || rd_eop) ev_len = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  logic       ev_any;
  logic [2:0] ev_code;

  always_comb begin
    ev_any = ev_sop | ev_short | ev_len | ev_dest | ev_data | ev_orphan;
    if (ev_sop)         ev_code = CODE_SOP;
    else if (ev_short)  ev_code = CODE_SHORT;
    else if (ev_len)    ev_code = CODE_LEN;
    else if (ev_dest)   ev_code = CODE_DEST;
    else if (ev_data)   ev_code = CODE_DATA;
    else if (ev_orphan) ev_code = CODE_ORPHAN;
    else                ev_code = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      len_q     <= '0;
      prio_q    <= '0;
      pkt_err   <= 1'b0;
`ifdef RX_PAYLOAD_CHECK_EN
      data_seen <= 1'b0;
`endif
      ready     <= 1'b0;
      pkt_done  <= 1'b0;
      last_len  <= '0;
      last_prio <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      err_code  <= '0;
      err_flag  <= 1'b0;
    end else begin
      ready    <= ~hold;
      pkt_done <= 1'b0;

      if (ev_any) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        err_code <= ev_code;
        err_flag <= 1'b1;
      end

      if (good) begin
        if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
        pkt_done  <= 1'b1;
        last_len  <= len_q;
        last_prio <= prio_q;
      end

      if (rd_vld) begin
        if (rd_sop) begin
          // A sop in any state restarts packet reception from this header.
          if (hdr_short) begin
            state <= S_IDLE;
          end else begin
            state     <= S_PAYLOAD;
            k         <= '0;
            len_q     <= hdr_len;
            prio_q    <= hdr_prio;
            pkt_err   <= hdr_dest_bad;
`ifdef RX_PAYLOAD_CHECK_EN
            data_seen <= 1'b0;
`endif
          end
        end else begin
          case (state)
            S_PAYLOAD: begin
              k <= k_inc;
              if (data_bad) begin
                pkt_err   <= 1'b1;
`ifdef RX_PAYLOAD_CHECK_EN
                data_seen <= 1'b1;
`endif
              end
              if (rd_eop)      state <= S_IDLE;
              else if (at_len) state <= S_DRAIN;
            end
            S_DRAIN: begin
              if (rd_eop) state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule
